// File: rtl/basys_mem_sequencer.sv
// basys_mem_sequencer: record/playback controller for the Basys dual-port block RAM.
// Record presses write SW into port A at an auto-incrementing address; playback
// steps port B through the stored words once every TICK_DIV cycles onto LED.
// Optional build macro: MEM_SEQ_ONESHOT_EN -- playback stops after the last
// stored word lands on LED instead of looping.
module basys_mem_sequencer #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] SW,
    input  logic [4:0]        BTN,
    output logic [DATA_W-1:0] LED,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    output logic              mem_ena,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addrb,
    output logic              mem_enb,
    input  logic [DATA_W-1:0] mem_doutb,
    output logic              busy,
    output logic              full
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // Button synchronizers and edge detection (bit 0 record, 1 play, 2 clear)
    logic [2:0] sync0;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] ev;
    logic       unused_btn;

    logic ev_rec;
    logic ev_play;
    logic ev_clr;

    // Controller state
    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_nx;
    logic [CNT_W-1:0]    count_last;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W-1:0]   rd_ptr_nx;
    logic [TICK_W-1:0]   tick;
    logic [TICK_W-1:0]   tick_nx;
    logic                rd_valid;
    logic                rd_valid_nx;

    // Next values of the registered outputs
    logic [DATA_W-1:0]   led_nx;
    logic [ADDR_W-1:0]   addra_nx;
    logic [DATA_W-1:0]   dina_nx;
    logic                wr_nx;
    logic [ADDR_W-1:0]   addrb_nx;
    logic                enb_nx;

    // Read-issue request and the address it uses
    logic                issue;
    logic [ADDR_W-1:0]   issue_ptr;

    assign unused_btn = ^BTN[4:3];

    assign ev_rec  = ev[0];
    assign ev_play = ev[1];
    assign ev_clr  = ev[2];

    assign busy       = (state == PLAY);
    assign full       = (count == DEPTH_C);
    assign count_last = count - CNT_W'(1);

    // Two-flop synchronizer plus registered rising-edge pulse per button
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync0 <= '0;
            sync1 <= '0;
            sync2 <= '0;
            ev    <= '0;
        end else begin
            sync0 <= BTN[2:0];
            sync1 <= sync0;
            sync2 <= sync1;
            ev    <= sync1 & ~sync2;
        end
    end

    // Next-state and output logic: clear beats play toggle beats record
    always_comb begin
        state_nx    = state;
        count_nx    = count;
        rd_ptr_nx   = rd_ptr;
        tick_nx     = tick;
        led_nx      = LED;
        addra_nx    = mem_addra;
        dina_nx     = mem_dina;
        wr_nx       = 1'b0;
        addrb_nx    = mem_addrb;
        enb_nx      = 1'b0;
        rd_valid_nx = mem_enb && !ev_clr;
        issue       = 1'b0;
        issue_ptr   = rd_ptr;

        // Count tracks completed writes, so full rises after the strobe cycle
        if (mem_wea) begin
            count_nx = count + CNT_W'(1);
        end

        // A read issued last cycle lands on LED regardless of state
        if (rd_valid) begin
            led_nx = mem_doutb;
        end

        if (ev_clr) begin
            state_nx  = IDLE;
            count_nx  = '0;
            rd_ptr_nx = '0;
            tick_nx   = '0;
            led_nx    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ev_play) begin
                        if (count != '0) begin
                            state_nx  = PLAY;
                            tick_nx   = '0;
                            issue     = 1'b1;
                            issue_ptr = '0;
                        end
                    end else if (ev_rec && !full) begin
                        wr_nx    = 1'b1;
                        addra_nx = count[ADDR_W-1:0];
                        dina_nx  = SW;
                        led_nx   = SW;
                    end
                end
                PLAY: begin
                    if (ev_play) begin
                        state_nx = IDLE;
                    end else begin
                        tick_nx = (tick == TICK_LAST) ? '0 : tick + TICK_W'(1);
                        issue   = (tick == TICK_LAST);
`ifdef MEM_SEQ_ONESHOT_EN
                        // Last stored word is landing now: stop and keep it shown
                        if (rd_valid && ({1'b0, mem_addrb} == count_last)) begin
                            state_nx = IDLE;
                            issue    = 1'b0;
                        end
`endif
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end

        // Launch a port-B read and advance the pointer, wrapping after count-1
        if (issue) begin
            enb_nx    = 1'b1;
            addrb_nx  = issue_ptr;
            rd_ptr_nx = ({1'b0, issue_ptr} == count_last) ? '0 : issue_ptr + ADDR_W'(1);
        end
    end

    // State and registered-output update
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            count     <= '0;
            rd_ptr    <= '0;
            tick      <= '0;
            rd_valid  <= 1'b0;
            LED       <= '0;
            mem_addra <= '0;
            mem_dina  <= '0;
            mem_ena   <= 1'b0;
            mem_wea   <= 1'b0;
            mem_addrb <= '0;
            mem_enb   <= 1'b0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            rd_ptr    <= rd_ptr_nx;
            tick      <= tick_nx;
            rd_valid  <= rd_valid_nx;
            LED       <= led_nx;
            mem_addra <= addra_nx;
            mem_dina  <= dina_nx;
            mem_ena   <= wr_nx;
            mem_wea   <= wr_nx;
            mem_addrb <= addrb_nx;
            mem_enb   <= enb_nx;
        end
    end

endmodule

// File: tb/tb_basys_mem_sequencer.sv
// Directed bench for basys_mem_sequencer with ADDR_W=2, TICK_DIV=4 and a
// one-cycle-latency dual-port memory model. Honours MEM_SEQ_ONESHOT_EN.
`timescale 1ns/1ps
module tb_basys_mem_sequencer;

    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned TICK_DIV = 4;

    logic              CLK = 1'b0;
    logic              RST;
    logic [DATA_W-1:0] SW;
    logic [4:0]        BTN;
    logic [DATA_W-1:0] LED;
    logic [ADDR_W-1:0] mem_addra;
    logic [DATA_W-1:0] mem_dina;
    logic              mem_ena;
    logic              mem_wea;
    logic [ADDR_W-1:0] mem_addrb;
    logic              mem_enb;
    logic [DATA_W-1:0] mem_doutb;
    logic              busy;
    logic              full;

    int checks = 0;
    int errors = 0;

    // Memory model and transaction log
    logic [DATA_W-1:0] mem [4];
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [DATA_W-1:0] wr_data_q [$];
    int wr_cnt = 0;
    int rd_cnt = 0;

    basys_mem_sequencer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .SW        (SW),
        .BTN       (BTN),
        .LED       (LED),
        .mem_addra (mem_addra),
        .mem_dina  (mem_dina),
        .mem_ena   (mem_ena),
        .mem_wea   (mem_wea),
        .mem_addrb (mem_addrb),
        .mem_enb   (mem_enb),
        .mem_doutb (mem_doutb),
        .busy      (busy),
        .full      (full)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_ena && mem_wea) begin
            mem[mem_addra] <= mem_dina;
            wr_addr_q.push_back(mem_addra);
            wr_data_q.push_back(mem_dina);
            wr_cnt++;
        end
        if (mem_enb) begin
            mem_doutb <= mem[mem_addrb];
            rd_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic press(input int b);
        BTN[b] = 1'b1;
        step(4);
        BTN[b] = 1'b0;
        step(5);
    endtask

    task automatic wait_busy(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: busy never rose within 10 cycles", name);
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        step(3);
        checks++;
        if ({LED, mem_addra, mem_dina, mem_ena, mem_wea, mem_addrb, mem_enb, busy, full} !== '0) begin
            errors++;
            $display("FAIL reset_values: led=%h addra=%h dina=%h ena=%b wea=%b addrb=%h enb=%b busy=%b full=%b, all required 0",
                     LED, mem_addra, mem_dina, mem_ena, mem_wea, mem_addrb, mem_enb, busy, full);
        end
        RST = 1'b0;
        step(2);
    endtask

    task automatic test_record;
        int wea_cycles;
        wea_cycles = 0;
        SW = 16'h1111;
        BTN[0] = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step(1);
            if (mem_wea) wea_cycles++;
            if (e == 2) begin
                checks++;
                if (mem_wea !== 1'b0) begin
                    errors++;
                    $display("FAIL rec_early_wea: got %b required 0", mem_wea);
                end
            end
            if (e == 3) begin
                checks++;
                if ({mem_ena, mem_wea, mem_addra, mem_dina} !== {1'b1, 1'b1, 2'd0, 16'h1111}) begin
                    errors++;
                    $display("FAIL rec_strobe: ena=%b wea=%b addra=%h dina=%h required 1 1 0 1111",
                             mem_ena, mem_wea, mem_addra, mem_dina);
                end
            end
            if (e == 4) begin
                checks++;
                if (mem_wea !== 1'b0 || LED !== 16'h1111) begin
                    errors++;
                    $display("FAIL rec_after: wea=%b led=%h required 0 1111", mem_wea, LED);
                end
            end
        end
        checks++;
        if (wea_cycles !== 1) begin
            errors++;
            $display("FAIL rec_hold_single: wea cycles %0d required 1", wea_cycles);
        end
        BTN[0] = 1'b0;
        step(4);
        SW = 16'h2222;
        press(0);
        SW = 16'h3333;
        press(0);
        checks++;
        if (wr_cnt !== 3) begin
            errors++;
            $display("FAIL rec_count: writes %0d required 3", wr_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            logic [DATA_W-1:0] exp_d;
            exp_d = DATA_W'((i + 1) * 16'h1111);
            checks++;
            if (wr_cnt == 3 && (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== exp_d)) begin
                errors++;
                $display("FAIL rec_log%0d: addr=%h data=%h required %h %h", i, wr_addr_q[i], wr_data_q[i], i, exp_d);
            end
        end
        checks++;
        if (LED !== 16'h3333 || full !== 1'b0) begin
            errors++;
            $display("FAIL rec_final: led=%h full=%b required 3333 0", LED, full);
        end
    endtask

    task automatic test_play;
        BTN[1] = 1'b1;
        for (int e = 0; e <= 28; e++) begin
            step(1);
            if (e == 4)  BTN[1] = 1'b0;
            if (e == 6)  BTN[0] = 1'b1;
            if (e == 10) BTN[0] = 1'b0;
`ifndef MEM_SEQ_ONESHOT_EN
            if (e == 17) BTN[1] = 1'b1;
            if (e == 21) BTN[1] = 1'b0;
`endif
            case (e)
                2: begin
                    checks++;
                    if (busy !== 1'b0 || mem_enb !== 1'b0) begin
                        errors++;
                        $display("FAIL play_pre: busy=%b enb=%b required 0 0", busy, mem_enb);
                    end
                end
                3, 7, 11: begin
                    checks++;
                    if (busy !== 1'b1 || mem_enb !== 1'b1 || mem_addrb !== ADDR_W'((e - 3) / 4)) begin
                        errors++;
                        $display("FAIL play_issue_e%0d: busy=%b enb=%b addrb=%h required 1 1 %h",
                                 e, busy, mem_enb, mem_addrb, (e - 3) / 4);
                    end
                end
                5, 9, 13: begin
                    logic [DATA_W-1:0] exp_l;
                    exp_l = DATA_W'(((e - 1) / 4) * 16'h1111);
                    checks++;
                    if (LED !== exp_l) begin
                        errors++;
                        $display("FAIL play_led_e%0d: got %h required %h", e, LED, exp_l);
                    end
                end
                14: begin
                    checks++;
`ifdef MEM_SEQ_ONESHOT_EN
                    if (busy !== 1'b0) begin
                        errors++;
                        $display("FAIL play_oneshot_end: busy=%b required 0", busy);
                    end
`else
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL play_loop_busy: busy=%b required 1", busy);
                    end
`endif
                end
                15: begin
                    checks++;
`ifdef MEM_SEQ_ONESHOT_EN
                    if (mem_enb !== 1'b0) begin
                        errors++;
                        $display("FAIL play_oneshot_noread: enb=%b required 0", mem_enb);
                    end
`else
                    if (mem_enb !== 1'b1 || mem_addrb !== 2'd0) begin
                        errors++;
                        $display("FAIL play_wrap: enb=%b addrb=%h required 1 0", mem_enb, mem_addrb);
                    end
`endif
                end
                17: begin
                    checks++;
`ifdef MEM_SEQ_ONESHOT_EN
                    if (LED !== 16'h3333) begin
                        errors++;
                        $display("FAIL play_hold: led=%h required 3333", LED);
                    end
`else
                    if (LED !== 16'h1111) begin
                        errors++;
                        $display("FAIL play_wrap_led: led=%h required 1111", LED);
                    end
`endif
                end
                21: begin
                    logic [DATA_W-1:0] exp_l;
`ifdef MEM_SEQ_ONESHOT_EN
                    exp_l = 16'h3333;
`else
                    exp_l = 16'h2222;
`endif
                    checks++;
                    if (busy !== 1'b0 || LED !== exp_l) begin
                        errors++;
                        $display("FAIL play_stop: busy=%b led=%h required 0 %h", busy, LED, exp_l);
                    end
                end
                default: ;
            endcase
        end
        checks++;
`ifdef MEM_SEQ_ONESHOT_EN
        if (rd_cnt !== 3) begin
            errors++;
            $display("FAIL play_reads: got %0d required 3", rd_cnt);
        end
`else
        if (rd_cnt !== 5) begin
            errors++;
            $display("FAIL play_reads: got %0d required 5", rd_cnt);
        end
`endif
        checks++;
        if (wr_cnt !== 3) begin
            errors++;
            $display("FAIL play_rec_ignored: writes %0d required 3", wr_cnt);
        end
    endtask

    task automatic test_clear_play;
        int rd0;
        bit seen;
        BTN[1] = 1'b1;
        wait_busy("clr_start");
        BTN[1] = 1'b0;
        step(2);
        BTN[1] = 1'b1;
        BTN[2] = 1'b1;
        step(4);
        BTN[1] = 1'b0;
        BTN[2] = 1'b0;
        step(5);
        checks++;
        if (busy !== 1'b0 || LED !== 16'h0000 || full !== 1'b0) begin
            errors++;
            $display("FAIL clear_play: busy=%b led=%h full=%b required 0 0000 0", busy, LED, full);
        end
        rd0 = rd_cnt;
        seen = 1'b0;
        BTN[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (i == 4) BTN[1] = 1'b0;
            if (busy) seen = 1'b1;
        end
        checks++;
        if (seen || rd_cnt !== rd0) begin
            errors++;
            $display("FAIL play_empty: busy_seen=%b reads=%0d required 0 %0d", seen, rd_cnt, rd0);
        end
    endtask

    task automatic test_full;
        for (int i = 0; i < 3; i++) begin
            SW = DATA_W'(16'hA000 + i);
            press(0);
        end
        SW = 16'hA003;
        BTN[0] = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            step(1);
            if (e == 3) begin
                checks++;
                if (mem_wea !== 1'b1 || mem_addra !== 2'd3 || full !== 1'b0) begin
                    errors++;
                    $display("FAIL full_last_write: wea=%b addra=%h full=%b required 1 3 0", mem_wea, mem_addra, full);
                end
            end
            if (e == 4) begin
                checks++;
                if (mem_wea !== 1'b0 || full !== 1'b1) begin
                    errors++;
                    $display("FAIL full_rise: wea=%b full=%b required 0 1", mem_wea, full);
                end
            end
        end
        BTN[0] = 1'b0;
        step(4);
        SW = 16'hBEEF;
        press(0);
        checks++;
        if (wr_cnt !== 7 || full !== 1'b1 || LED !== 16'hA003) begin
            errors++;
            $display("FAIL full_reject: writes=%0d full=%b led=%h required 7 1 a003", wr_cnt, full, LED);
        end
        for (int i = 0; i < 4; i++) begin
            logic [DATA_W-1:0] exp_d;
            exp_d = DATA_W'(16'hA000 + i);
            checks++;
            if (wr_cnt == 7 && (wr_addr_q[3 + i] !== ADDR_W'(i) || wr_data_q[3 + i] !== exp_d)) begin
                errors++;
                $display("FAIL full_log%0d: addr=%h data=%h required %h %h", i, wr_addr_q[3 + i], wr_data_q[3 + i], i, exp_d);
            end
        end
    endtask

    task automatic test_reset_mid_play;
        int rd0;
        bit seen;
        BTN[1] = 1'b1;
        wait_busy("rst_play_start");
        BTN[1] = 1'b0;
        step(2);
        RST = 1'b1;
        step(1);
        checks++;
        if ({LED, mem_addra, mem_dina, mem_ena, mem_wea, mem_addrb, mem_enb, busy, full} !== '0) begin
            errors++;
            $display("FAIL rst_mid_play: led=%h addra=%h dina=%h ena=%b wea=%b addrb=%h enb=%b busy=%b full=%b, all required 0",
                     LED, mem_addra, mem_dina, mem_ena, mem_wea, mem_addrb, mem_enb, busy, full);
        end
        RST = 1'b0;
        step(2);
        rd0 = rd_cnt;
        seen = 1'b0;
        BTN[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (i == 4) BTN[1] = 1'b0;
            if (busy) seen = 1'b1;
        end
        checks++;
        if (seen || rd_cnt !== rd0) begin
            errors++;
            $display("FAIL rst_play_ignored: busy_seen=%b reads=%0d required 0 %0d", seen, rd_cnt, rd0);
        end
    endtask

    task automatic test_reset_mid_write;
        SW = 16'h5555;
        BTN[0] = 1'b1;
        step(3);
        RST = 1'b1;
        BTN[0] = 1'b0;
        step(1);
        checks++;
        if (mem_wea !== 1'b0 || mem_ena !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_write: ena=%b wea=%b required 0 0", mem_ena, mem_wea);
        end
        RST = 1'b0;
        step(5);
        checks++;
        if (wr_cnt !== 7) begin
            errors++;
            $display("FAIL rst_write_dropped: writes %0d required 7", wr_cnt);
        end
        SW = 16'h6666;
        press(0);
        checks++;
        if (wr_cnt !== 8 || wr_addr_q[wr_addr_q.size() - 1] !== 2'd0 ||
            wr_data_q[wr_data_q.size() - 1] !== 16'h6666 || LED !== 16'h6666) begin
            errors++;
            $display("FAIL rec_after_reset: writes=%0d addr=%h data=%h led=%h required 8 0 6666 6666",
                     wr_cnt, wr_addr_q[wr_addr_q.size() - 1], wr_data_q[wr_data_q.size() - 1], LED);
        end
    endtask

    initial begin
        RST = 1'b1;
        BTN = '0;
        SW  = '0;
        test_reset();
        test_record();
        test_play();
        test_clear_play();
        test_full();
        test_reset_mid_play();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
